// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, redirect from execute,
// and the valid/ready queue-head handshake toward decode.
interface fetch_stage_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;

    modport master (
        output pc, id_valid, id_pc, id_inst, id_pc_plus4,
        input  inst, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  pc, id_valid, id_pc, id_inst, id_pc_plus4,
        output inst, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: registered PC into combinational imem, {pc, inst} pairs
// buffered in a small FIFO toward decode; redirects flush and retarget the PC.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master fif
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pc_q;
    logic               id_valid, full, deq, enq;

    assign id_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign deq      = id_valid && fif.id_ready;
    // A full queue can still take a new word when the head leaves on the same edge.
    assign enq      = !fif.redirect && (!full || deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fif.redirect) begin
            pc_q   <= {fif.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc_q   <= pc_q + 32'd4;
            end
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)
                count <= count + CNT_W'(1);
            else if (deq && !enq)
                count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= '{pc: pc_q, inst: fif.inst};
    end

    assign head            = mem[rd_ptr];
    assign fif.pc          = pc_q;
    assign fif.id_valid    = id_valid;
    assign fif.id_pc       = id_valid ? head.pc           : '0;
    assign fif.id_inst     = id_valid ? head.inst         : '0;
    assign fif.id_pc_plus4 = id_valid ? head.pc + 32'd4   : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, backpressure, redirect flush,
// back-to-back redirects, PC wrap with negative addresses, async reset.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_stage_if fif ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    always #5 clk = ~clk;

    // Memory model: word k = 0x1000 + k, zero for negative addresses.
    assign fif.inst = fif.pc[31] ? 32'h0 : (32'h0000_1000 + (fif.pc >> 2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] p, input logic [31:0] i);
        chk({tag, " valid"}, {31'b0, fif.id_valid}, 32'd1);
        chk({tag, " id_pc"}, fif.id_pc, p);
        chk({tag, " id_inst"}, fif.id_inst, i);
        chk({tag, " plus4"}, fif.id_pc_plus4, p + 32'd4);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fif.redirect    = 1'b0;
        fif.redirect_pc = 32'h0;
        fif.id_ready    = 1'b1;
        #2;
        chk("rst pc", fif.pc, 32'h0);
        chk("rst valid", {31'b0, fif.id_valid}, 32'd0);
        chk("rst id_pc", fif.id_pc, 32'h0);
        chk("rst id_inst", fif.id_inst, 32'h0);
        chk("rst plus4", fif.id_pc_plus4, 32'h0);
        tick; tick;
        rst_n = 1'b1;

        // Stream with ready high
        tick; head("s0", 32'h0, 32'h1000); chk("s0 pc", fif.pc, 32'h4);
        tick; head("s1", 32'h4, 32'h1001);
        tick; head("s2", 32'h8, 32'h1002);
        tick; head("s3", 32'hC, 32'h1003); chk("s3 pc", fif.pc, 32'h10);

        // Redirect to 0 with ready low, then hold off decode
        fif.redirect = 1'b1; fif.redirect_pc = 32'h0; fif.id_ready = 1'b0;
        tick; fif.redirect = 1'b0;
        chk("bp flush valid", {31'b0, fif.id_valid}, 32'd0);
        chk("bp flush pc", fif.pc, 32'h0);
        tick; head("bp1", 32'h0, 32'h1000); chk("bp1 pc", fif.pc, 32'h4);
        tick; head("bp2", 32'h0, 32'h1000); chk("bp2 pc", fif.pc, 32'h8);
        tick; head("bp3", 32'h0, 32'h1000); chk("bp3 pc", fif.pc, 32'h8);
        tick; head("bp4", 32'h0, 32'h1000); chk("bp4 pc", fif.pc, 32'h8);
        fif.id_ready = 1'b1;
        tick; head("bp rel1", 32'h4, 32'h1001); chk("bp rel1 pc", fif.pc, 32'hC);

        // Queue holds 4 and 8: redirect to 0x43
        fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_0043; fif.id_ready = 1'b0;
        tick; fif.redirect = 1'b0; fif.id_ready = 1'b1;
        chk("rf valid", {31'b0, fif.id_valid}, 32'd0);
        chk("rf pc", fif.pc, 32'h40);
        tick; head("rf h0", 32'h40, 32'h1010);
        tick; head("rf h1", 32'h44, 32'h1011);

        // Redirect coinciding with handshake, then a second one to 0x80
        fif.redirect = 1'b1; fif.redirect_pc = 32'h20;
        tick;
        chk("rr1 valid", {31'b0, fif.id_valid}, 32'd0);
        chk("rr1 pc", fif.pc, 32'h20);
        fif.redirect_pc = 32'h80;
        tick; fif.redirect = 1'b0;
        chk("rr2 valid", {31'b0, fif.id_valid}, 32'd0);
        chk("rr2 pc", fif.pc, 32'h80);
        tick; head("rr h0", 32'h80, 32'h1020);
        tick; head("rr h1", 32'h84, 32'h1021);

        // Negative addresses and wrap
        fif.redirect = 1'b1; fif.redirect_pc = 32'hFFFF_FFF8;
        tick; fif.redirect = 1'b0;
        chk("wr pc", fif.pc, 32'hFFFF_FFF8);
        tick; head("wr h0", 32'hFFFF_FFF8, 32'h0);
        tick; head("wr h1", 32'hFFFF_FFFC, 32'h0);
        chk("wr h1 plus4", fif.id_pc_plus4, 32'h0);
        tick; head("wr h2", 32'h0, 32'h1000);
        tick; head("wr h3", 32'h4, 32'h1001);

        // Fill the queue, then async reset between edges
        fif.id_ready = 1'b0;
        tick; tick;
        head("ar full", 32'h4, 32'h1001);
        chk("ar full pc", fif.pc, 32'hC);
        #2 rst_n = 1'b0;
        #1;
        chk("ar valid", {31'b0, fif.id_valid}, 32'd0);
        chk("ar pc", fif.pc, 32'h0);
        chk("ar id_pc", fif.id_pc, 32'h0);
        chk("ar plus4", fif.id_pc_plus4, 32'h0);
        fif.id_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        tick; head("ar s0", 32'h0, 32'h1000);
        tick; head("ar s1", 32'h4, 32'h1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RISC-V core. Generates the program counter that drives the combinational instruction memory, captures each returned instruction together with its PC, and buffers the pair in a 2-entry queue. Decode consumes the queue through a valid/ready handshake. Branch and jump resolution redirects the PC and flushes any queued wrong-path instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, default 2: queue entries. Legal values are 2 and 4 only.
- `CLK`, input, 1: rising-edge clock.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `PC`, output, 32: fetch address to instruction memory. Registered.
- `INST`, input, 32: instruction word from instruction memory. Combinational function of `PC` within the same cycle. Reads 0 when `PC` is negative as a signed value.
- `REDIRECT`, input, 1: taken branch or jump from execute. One-cycle pulse.
- `REDIRECT_PC`, input, 32: target address. Bits [1:0] are ignored and treated as 00.
- `ID_VALID`, output, 1: queue head holds a valid instruction.
- `ID_READY`, input, 1: decode accepts the head this cycle.
- `ID_PC`, output, 32: PC of the head entry.
- `ID_INST`, output, 32: instruction of the head entry.
- `ID_PC_PLUS4`, output, 32: `ID_PC + 4`, computed modulo 2^32.

## Operation
- **State:** fetch PC register, queue storage, read pointer, write pointer, and an occupancy count (0..DEPTH).
- **Dequeue:** occurs when `ID_VALID && ID_READY`. Advances the read pointer.
- **Enqueue (normal cycle):**
  - Allowed when count < DEPTH, or when a dequeue happens in the same cycle.
  - On enqueue, `{PC, INST}` is written at the write pointer and the PC advances by 4.
  - Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No trap.
- **Stall:** queue full and no dequeue. The PC holds and no enqueue occurs. `INST` is re-read next cycle. Memory is stateless, so nothing is lost.
- **Redirect cycle:** `REDIRECT`=1.
  - Queue is flushed: count becomes 0 and both pointers reset.
  - No enqueue occurs this cycle.
  - PC is set to `{REDIRECT_PC[31:2], 2'b00}`.
  - Redirect takes priority over any simultaneous enqueue or dequeue. A handshake on the redirect cycle is still considered accepted by decode, and decode is responsible for squashing it.
- **Back-to-back redirects:** the last one wins. Each redirect flushes again.
- **Negative PC:** fetched normally. Word 0 is enqueued as the instruction. No special handling.
- **Outputs:** `ID_PC`, `ID_INST`, and `ID_PC_PLUS4` come from the queue head. Their values are don't-care when `ID_VALID`=0, but they are driven to 0 after reset.
- **Handshake rules:**
  - `ID_VALID` depends only on registered state.
  - The head entry must stay stable while `ID_VALID`=1 and `ID_READY`=0, unless a redirect occurs.

## Timing
- **Reset, asserted asynchronously:**
  - `PC` = `RESET_PC`
  - count = 0, `ID_VALID` = 0
  - `ID_PC` = 0, `ID_INST` = 0, `ID_PC_PLUS4` = 0
- **Reset mid-operation:** same as above, regardless of queue contents or a pending redirect.
- **First edge after reset release:** the instruction at `RESET_PC` is enqueued. `ID_VALID` rises in the following cycle.
- **Latency:** 1 cycle from `PC` presentation to the entry at the queue head, when the queue is empty.
- **Throughput:** 1 instruction per cycle with `ID_READY` held high. The queue stays at count 1 in steady state.
- **Redirect latency:**
  - Redirect is sampled at edge N.
  - `ID_VALID`=0 during cycle N+1, while `PC` = target.
  - The target instruction is at the head in cycle N+2.
  - Redirect penalty: 1 bubble at decode, plus whatever execute depth the core adds.
- **Full queue:** with `ID_READY`=0, `ID_VALID` stays high and `PC` freezes after DEPTH enqueues. When `ID_READY` rises, dequeue and enqueue occur on the same edge.

## Test plan
- **Reset and stream:**
  - Stimulus: memory word k = 32'h0000_1000 + k, `ID_READY`=1, `RST_N` released.
  - Required response: `ID_VALID` rises one cycle after the first edge. The sequence `ID_PC` = 0, 4, 8, 12 pairs with `ID_INST` = 0x1000, 0x1001, 0x1002, 0x1003 with no gaps, and `ID_PC_PLUS4` = `ID_PC` + 4.
- **Backpressure:**
  - Stimulus: `ID_READY`=0 for 5 cycles, then 1.
  - Required response: `PC` freezes at 8 (DEPTH=2). The head holds PC 0 stable. After release, PCs 0, 4, 8 come out in order with no duplicates and no drops.
- **Redirect flush:**
  - Stimulus: with the queue holding PC 4 and PC 8, `REDIRECT`=1 and `REDIRECT_PC` = 32'h0000_0043.
  - Required response: `ID_VALID`=0 the next cycle with `PC` = 0x40. `ID_PC` = 0x40 the cycle after. PCs 4 and 8 are never presented again.
- **Redirect with handshake:**
  - Stimulus: `REDIRECT` coincides with `ID_VALID && ID_READY`, then a second redirect arrives 1 cycle later to 0x80.
  - Required response: the final head is 0x80. No entry from the first target remains.
- **PC wrap and negative address:**
  - Stimulus: redirect to 32'hFFFF_FFF8.
  - Required response: `ID_PC` = FFFF_FFF8 with `ID_INST` = 0, then FFFF_FFFC with `ID_INST` = 0, then 0 with the word at index 0, then 4.
- **Asynchronous reset mid-stream:**
  - Stimulus: drop `RST_N` between edges with the queue full.
  - Required response: `ID_VALID` = 0 and `PC` = `RESET_PC` immediately, before the next edge. Restart behaves as in the reset-and-stream test.
